// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lbp_pkg
// Purpose  : Shared defaults and types for the BRAM frame reader.
//            - Default pixel/address widths and frame geometry.
//            - Reader FSM state encoding.
//            - FIFO entry type carrying a pixel and its stream tags.
// Revision : 1.0  initial release
// ============================================================================
package lbp_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_ADDR_WIDTH = 19;
  localparam int DEF_IMG_W      = 400;
  localparam int DEF_IMG_H      = 300;
  localparam int FRAME_PIXELS   = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // One buffered beat: pixel plus end-of-line and start-of-frame tags.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
    logic                      sof;
  } pix_entry_t;

endpackage
`default_nettype wire

// File: rtl/reader_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reader_skid_fifo
// Purpose  : Two-entry register FIFO absorbing the BRAM read latency.
// Ports    : clk         clock
//            rst_n       asynchronous active-low reset
//            i_push      write i_push_data this edge (caller never pushes full)
//            i_push_data entry to store
//            i_pop       drop head this edge (caller never pops empty)
//            o_head      current head entry
//            o_count     occupancy, 0..2
// Revision : 1.0  initial release
// ============================================================================
module reader_skid_fifo
  import lbp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  pix_entry_t i_push_data,
  input  logic       i_pop,
  output pix_entry_t o_head,
  output logic [1:0] o_count
);

  pix_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_frame_reader
// Purpose  : Streams one frame from the BRAM read port in raster order as a
//            valid/ready pixel stream with end-of-line and start-of-frame
//            tags. Absorbs the 1-cycle BRAM read latency in a 2-entry FIFO
//            so consumer stalls never drop or duplicate pixels.
// Ports    : r_clk    read clock (shared with BRAM read port)
//            rst_n    asynchronous active-low reset
//            start    frame request (ignored while busy or during done)
//            busy     frame in progress
//            done     one-cycle pulse after the final beat is accepted
//            r_addr   registered BRAM read address
//            r_data   BRAM read data, one cycle after r_addr
//            m_data   output pixel      m_valid  output beat valid
//            m_ready  consumer ready    m_last   last pixel of a line
//            m_sof    first pixel of the frame
// Revision : 1.0  initial release
// ============================================================================
module bram_frame_reader
  import lbp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,  // must equal DEF_DATA_WIDTH
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H       // IMG_W*IMG_H <= 2**ADDR_WIDTH
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  m_sof
);

  localparam int                    c_x_w       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [c_x_w-1:0]      c_last_x    = c_x_w'(IMG_W - 1);

  rd_state_t        r_state;
  rd_state_t        w_next_state;
  logic [c_x_w-1:0] r_x_rd;
  logic             r_inflight;
  logic             r_tag_last;
  logic             r_tag_sof;
  logic             r_done;

  logic [1:0]       w_fifo_count;
  logic [2:0]       w_occupancy;
  pix_entry_t       w_head;
  pix_entry_t       w_push_entry;
  logic             w_valid;
  logic             w_pop;
  logic             w_issue;
  logic             w_accept_start;
  logic             w_final_pop;

  assign w_valid = (w_fifo_count != 2'd0);
  assign w_pop   = w_valid && m_ready;

  // Occupancy after this edge if nothing new is issued. Counting the pop
  // that happens in this cycle lets a steady ready stream run at one beat
  // per cycle while still bounding FIFO + in-flight at two entries.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == ST_READ) && (w_occupancy < 3'd2);

  // The cycle carrying done is already IDLE, but a start seen there belongs
  // to the frame just finished and is dropped.
  assign w_accept_start = (r_state == ST_IDLE) && start && !r_done;

  // The last read has been issued before DRAIN, so the frame ends when the
  // only remaining entry leaves and nothing is still coming from the BRAM.
  assign w_final_pop = (r_state == ST_DRAIN) && w_pop &&
                       (w_fifo_count == 2'd1) && !r_inflight;

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept_start) w_next_state = ST_READ;
      ST_READ:  if (w_issue && (r_addr == c_last_addr)) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_final_pop) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Address/column counters, in-flight flag and the tags that travel with
  // the outstanding read until its data returns.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_x_rd     <= '0;
      r_inflight <= 1'b0;
      r_tag_last <= 1'b0;
      r_tag_sof  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_final_pop;
      if (w_accept_start) begin
        r_addr <= '0;
        r_x_rd <= '0;
      end else if (w_issue) begin
        r_tag_last <= (r_x_rd == c_last_x);
        r_tag_sof  <= (r_addr == '0);
        // Hold on the final address so r_addr never leaves the frame.
        if (r_addr != c_last_addr) begin
          r_addr <= r_addr + 1'b1;
        end
        r_x_rd <= (r_x_rd == c_last_x) ? '0 : r_x_rd + 1'b1;
      end
    end
  end

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = r_data;
    w_push_entry.last = r_tag_last;
    w_push_entry.sof  = r_tag_sof;
  end

  reader_skid_fifo u_fifo (
    .clk         (r_clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count)
  );

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign m_valid = w_valid;
  assign m_data  = w_valid ? w_head.data : '0;
  assign m_last  = w_valid && w_head.last;
  assign m_sof   = w_valid && w_head.sof;

endmodule
`default_nettype wire

// File: tb/tb_bram_frame_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bram_frame_reader
// Purpose  : Self-checking bench for bram_frame_reader. Instance A is a 4x3
//            frame driven from a per-cycle vector table and hand sequences;
//            instance B is a 40x30 frame with random consumer backpressure.
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_frame_reader;

  localparam int DW = 12;
  localparam int AW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, busy, done, m_valid, m_ready, m_last, m_sof;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data, m_data;

  logic          start_b, busy_b, done_b, m_valid_b, m_ready_b, m_last_b, m_sof_b;
  logic [AW-1:0] r_addr_b;
  logic [DW-1:0] r_data_b, m_data_b;

  int errors;
  int checks;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = a[DW-1:0];
    return t + 12'h100;
  endfunction

  // BRAM models: registered read, mem[i] = i + 0x100
  always @(posedge clk) r_data   <= mem_word(r_addr);
  always @(posedge clk) r_data_b <= mem_word(r_addr_b);

  bram_frame_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(4), .IMG_H(3)) u_a (
    .r_clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .r_addr(r_addr), .r_data(r_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .m_sof(m_sof)
  );

  bram_frame_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(40), .IMG_H(30)) u_b (
    .r_clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .r_addr(r_addr_b), .r_data(r_data_b), .m_data(m_data_b), .m_valid(m_valid_b),
    .m_ready(m_ready_b), .m_last(m_last_b), .m_sof(m_sof_b)
  );

  typedef struct {
    logic          start;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          sof;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; start_b = 1'b0; m_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy",  busy,    0);
    chk("rst_done",  done,    0);
    chk("rst_addr",  r_addr,  0);
    chk("rst_fifo",  u_a.w_fifo_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Apply one table row for one cycle and compare outputs mid-cycle.
  task automatic run_row(input vec_t v, input string tag, input int idx);
    start   = v.start;
    m_ready = v.ready;
    @(negedge clk);
    chk($sformatf("%s[%0d].valid", tag, idx), m_valid, v.valid);
    chk($sformatf("%s[%0d].busy",  tag, idx), busy,    v.busy);
    chk($sformatf("%s[%0d].done",  tag, idx), done,    v.done);
    chk($sformatf("%s[%0d].addr",  tag, idx), r_addr,  v.addr);
    if (v.valid) begin
      chk($sformatf("%s[%0d].data", tag, idx), m_data, v.data);
      chk($sformatf("%s[%0d].last", tag, idx), m_last, v.last);
      chk($sformatf("%s[%0d].sof",  tag, idx), m_sof,  v.sof);
    end
    @(posedge clk);
    #1;
  endtask

  // Start a 4x3 frame on instance A and consume it. Optional stall of
  // stall_len cycles after beat stall_after, optional reset at beat rst_at.
  task automatic consume(input string tag, input int stall_after, input int stall_len,
                         input int rst_at);
    int  n = 0, nd = 0, after = 0, stall_left = 0, bad_addr = 0, cyc = 0;
    bit  stop = 0, check_stall = 0, was_reset = 0;
    m_ready = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < 200 && !stop) begin
      cyc++;
      @(negedge clk);
      if (done) nd++;
      if (r_addr > 19'd11) bad_addr++;
      if (check_stall) begin
        check_stall = 0;
        chk({tag, ".stall_addr"}, r_addr, 8);
        chk({tag, ".stall_fifo"}, u_a.w_fifo_count, 2);
      end
      if (rst_at >= 0 && m_valid && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_valid"}, m_valid, 0);
        chk({tag, ".rst_busy"},  busy,    0);
        chk({tag, ".rst_addr"},  r_addr,  0);
        chk({tag, ".rst_outs"},  {m_data, m_last, m_sof, done}, 0);
        was_reset = 1;
        stop = 1;
      end else begin
        if (m_valid && m_ready) begin
          chk($sformatf("%s.beat%0d.data", tag, n), m_data, mem_word(AW'(n)));
          chk($sformatf("%s.beat%0d.tags", tag, n), {m_last, m_sof},
              {(n % 4) == 3, n == 0});
          n++;
          if (n == stall_after + 1 && stall_len > 0) stall_left = stall_len;
        end
        if (nd > 0) after++;
        if (after > 3) stop = 1;
      end
      if (!stop) begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
          m_ready = 1'b0;
          stall_left--;
          if (stall_left == 0) check_stall = 1;
        end else begin
          m_ready = 1'b1;
        end
      end
    end
    if (was_reset) begin
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      chk({tag, ".beats"},    n,        12);
      chk({tag, ".dones"},    nd,       1);
      chk({tag, ".busy_end"}, busy,     0);
      chk({tag, ".addr_max"}, bad_addr, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t v;
    int   n, nd, lasts, sofs, bad, after, cyc, bad_addr;
    errors = 0;
    checks = 0;

    //          start rdy val data     lst sof addr busy done
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 19'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 19'd0,  1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 19'd1,  1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 12'h100, 1'b0, 1'b1, 19'd2,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'h101, 1'b0, 1'b0, 19'd3,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 12'h102, 1'b0, 1'b0, 19'd4,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 12'h103, 1'b1, 1'b0, 19'd5,  1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 12'h104, 1'b0, 1'b0, 19'd6,  1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 12'h105, 1'b0, 1'b0, 19'd7,  1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 12'h106, 1'b0, 1'b0, 19'd8,  1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 12'h107, 1'b1, 1'b0, 19'd9,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 12'h108, 1'b0, 1'b0, 19'd10, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 12'h109, 1'b0, 1'b0, 19'd11, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 12'h10A, 1'b0, 1'b0, 19'd11, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 12'h10B, 1'b1, 1'b0, 19'd11, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 19'd11, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 19'd11, 1'b0, 1'b0};

    // Plain frame with m_ready held high
    do_reset();
    for (int i = 0; i < 17; i++) run_row(tbl[i], "base", i);

    // Same frame with start re-pulsed at beat 4: must be ignored
    do_reset();
    for (int i = 0; i < 17; i++) begin
      v = tbl[i];
      if (i == 7) v.start = 1'b1;
      run_row(v, "restart", i);
    end

    // start in the done cycle is dropped; start one cycle later begins frame 2
    do_reset();
    for (int i = 0; i < 17; i++) begin
      v = tbl[i];
      if (i == 15 || i == 16) v.start = 1'b1;
      run_row(v, "b2b_f1", i);
    end
    for (int i = 1; i < 17; i++) run_row(tbl[i], "b2b_f2", i);

    // Consumer stall after beat 5
    do_reset();
    consume("stall", 5, 10, -1);

    // Reset mid-frame, then a clean frame
    do_reset();
    consume("midrst", -1, 0, 6);
    consume("postrst", -1, 0, -1);

    // Random backpressure on a 40x30 frame
    do_reset();
    n = 0; nd = 0; lasts = 0; sofs = 0; bad = 0; after = 0; cyc = 0; bad_addr = 0;
    start_b = 1'b1;
    m_ready_b = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    start_b = 1'b0;
    while (cyc < 8000 && after < 4) begin
      cyc++;
      @(negedge clk);
      if (done_b) nd++;
      if (nd > 0) after++;
      if (r_addr_b > 19'd1199) bad_addr++;
      if (m_valid_b && m_ready_b) begin
        if (m_data_b !== mem_word(AW'(n))) bad++;
        if (m_last_b !== ((n % 40) == 39)) bad++;
        if (m_sof_b !== (n == 0)) bad++;
        if (m_last_b) lasts++;
        if (m_sof_b) sofs++;
        n++;
      end
      @(posedge clk);
      #1;
      m_ready_b = 1'($urandom_range(0, 1));
    end
    chk("rand.beats",    n,        1200);
    chk("rand.order",    bad,      0);
    chk("rand.lasts",    lasts,    30);
    chk("rand.sofs",     sofs,     1);
    chk("rand.dones",    nd,       1);
    chk("rand.addr_max", bad_addr, 0);
    chk("rand.busy_end", busy_b,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
